memory_responder: RTL and testbench
===================================

# memory_responder

Bus-side counterpart to the 6502 core: it answers the core's address / read_write / data_write requests and returns data_read. It contains on-chip RAM, a fixed reset vector, and one memory-mapped I/O page. The I/O page has a transmit FIFO that drains to an external consumer over a valid/ready handshake, and a single-byte receive latch filled by an external producer. It sits between the core and the board-level peripherals, and is the only block that drives data_read.

## Interface
Parameters:
- RAM_ADDR_BITS, 11: RAM occupies 0x0000 to 2^RAM_ADDR_BITS−1.
- IO_PAGE, 8'hD0: high address byte of the I/O page.
- TX_DEPTH, 4: transmit FIFO entries; must be a power of two, ≥2.
- RESET_VECTOR, 16'h0200: value returned at 0xFFFC (low byte) and 0xFFFD (high byte).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- address, input, 16: bus address from the core.
- read_write, input, 1: 1 = read, 0 = write (6502 convention).
- data_write, input, 8: write data from the core.
- data_read, output, 8: registered read data to the core.
- tx_data, output, 8: FIFO head byte.
- tx_valid, output, 1: FIFO non-empty.
- tx_ready, input, 1: consumer accepts the head byte when high together with tx_valid.
- rx_data, input, 8: producer byte.
- rx_valid, input, 1: producer byte present.
- rx_ready, output, 1: receive latch empty.

## Operation
- Every clock cycle is one bus access. Decode priority:
  1. RAM.
  2. I/O page (address[15:8] == IO_PAGE).
  3. Vectors 0xFFFC/0xFFFD.
  4. Unmapped: reads return 0x00, writes are ignored.
- RAM writes: when read_write=0, mem[address] ← data_write at the edge.
- RAM reads: data_read ← mem[address] at the edge. Write-then-read of the same address in consecutive cycles returns the new value. RAM contents are not reset.
- I/O registers (address[7:0]):
  - 0x00 TXDATA: a write pushes data_write into the FIFO. A read returns 0x00.
  - 0x01 STATUS (read): {4'b0, overflow, rx_full, tx_empty, tx_full}. Reading STATUS clears overflow at the same edge; the returned value shows the pre-clear state. Writes are ignored.
  - 0x02 RXDATA (read): returns the latched byte and clears rx_full. A read while the latch is empty returns 0x00 with no side effect.
  - 0x03–0xFF: read 0x00, writes are ignored.
- The core presents each side-effecting access for exactly one cycle. A repeated presentation is treated as a second access.
- TX FIFO:
  - Pop when tx_valid && tx_ready.
  - A push is accepted if count after that cycle's pop < TX_DEPTH. Full + pop + push in the same cycle is therefore accepted.
  - A rejected push drops the byte and sets sticky overflow.
  - Pointers wrap modulo TX_DEPTH. count is log2(TX_DEPTH)+1 bits.
- RX latch:
  - rx_ready = !rx_full.
  - rx_valid && rx_ready loads rx_data and sets rx_full.
  - A CPU RXDATA read and a new rx_valid in the same cycle: the read clears the latch, and the new byte is not accepted because rx_ready was low that cycle.
- Reset (asynchronous, active-low):
  - data_read=0x00, FIFO empty (tx_valid=0, tx_data=0x00), overflow=0, rx_full=0 (rx_ready=1).
  - Assertion mid-transfer discards FIFO and latch contents immediately.
  - Release is synchronous to clk: the first access is serviced on the first rising edge after rst_n goes high.

## Timing
- Read latency is 1: the address presented before edge k yields data_read valid after edge k, held until the next edge.
- Write latency is 1: the value is visible to a read issued the following cycle.
- Status flags, tx_valid and rx_ready update at the same edge as the access or handshake that causes them. There is no combinational bypass from push to tx_valid; an empty FIFO shows tx_valid 1 cycle after the push.
- tx_data is the head entry; it is stable while tx_valid=1 && tx_ready=0.
- Vector reads are one cycle each: 0xFFFC→RESET_VECTOR[7:0], 0xFFFD→RESET_VECTOR[15:8].

## Test plan
- Reset, then read 0xFFFC and 0xFFFD → data_read 0x00 and 0x02 on successive cycles; read 0x5000 → 0x00.
- Write 0xA5 to 0x0123, read 0x0123 the next cycle → 0xA5. Write 0x3C to 0x0800 (unmapped) and read it → 0x00.
- tx_ready=0; push 0x11, 0x22, 0x33, 0x44, 0x55 to 0xD000 → STATUS=0x09 (overflow, full). A second STATUS read → 0x01. Raise tx_ready → 0x11, 0x22, 0x33, 0x44 appear on tx_data over 4 cycles, then tx_valid=0 and STATUS=0x02.
- FIFO full, tx_ready=1, push 0x66 in the same cycle → no overflow; 0x66 drains last.
- rx_valid=1, rx_data=0x7E → rx_ready=0 next cycle and STATUS bit2=1. Read 0xD002 → 0x7E, and rx_ready=1 the following cycle. Read 0xD002 again → 0x00.
- Assert rst_n low mid-drain with 2 bytes queued → tx_valid=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/memory_responder.sv
// Bus responder for the 6502 core: on-chip RAM, reset vector and one I/O page
// holding a transmit FIFO (valid/ready drain) and a single-byte receive latch.
module memory_responder #(
  parameter int unsigned RAM_ADDR_BITS = 11,
  parameter logic [7:0]  IO_PAGE       = 8'hD0,
  parameter int unsigned TX_DEPTH      = 4,
  parameter logic [15:0] RESET_VECTOR  = 16'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic        read_write,
  input  logic [7:0]  data_write,
  output logic [7:0]  data_read,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned RAM_WORDS = 1 << RAM_ADDR_BITS;
  localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [7:0] REG_TXDATA = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_RXDATA = 8'h02;

  logic [7:0]       mem [RAM_WORDS];
  logic [7:0]       fifo [TX_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             rx_full;
  logic [7:0]       rx_byte;

  logic                     ram_hit, io_hit;
  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic [7:0]               io_reg;
  logic                     wr_tx, rd_status, rd_rx;
  logic                     pop, push_ok, rx_load;
  logic                     tx_full, tx_empty;
  logic [7:0]               status;
  logic [7:0]               rd_mux;

  // Address decode; RAM wins over the I/O page, which wins over the vectors.
  always_comb begin
    ram_hit   = (32'(address) >> RAM_ADDR_BITS) == 32'd0;
    io_hit    = !ram_hit && (address[15:8] == IO_PAGE);
    ram_idx   = address[RAM_ADDR_BITS-1:0];
    io_reg    = address[7:0];
    wr_tx     = io_hit && !read_write && (io_reg == REG_TXDATA);
    rd_status = io_hit &&  read_write && (io_reg == REG_STATUS);
    rd_rx     = io_hit &&  read_write && (io_reg == REG_RXDATA);
  end

  // Handshakes; a push is judged against the occupancy left after this cycle's pop.
  always_comb begin
    tx_full  = count == CNT_W'(TX_DEPTH);
    tx_empty = count == CNT_W'(0);
    tx_valid = !tx_empty;
    tx_data  = fifo[rd_ptr];
    rx_ready = !rx_full;
    pop      = tx_valid && tx_ready;
    push_ok  = wr_tx && ((count - CNT_W'(pop)) < CNT_W'(TX_DEPTH));
    rx_load  = rx_valid && !rx_full;
    status   = {4'b0000, overflow, rx_full, tx_empty, tx_full};
  end

  // Read data selection from pre-edge state.
  always_comb begin
    rd_mux = 8'h00;
    if (ram_hit) begin
      rd_mux = mem[ram_idx];
    end else if (io_hit) begin
      if (io_reg == REG_STATUS)                rd_mux = status;
      else if (io_reg == REG_RXDATA && rx_full) rd_mux = rx_byte;
    end else if (address == 16'hFFFC) begin
      rd_mux = RESET_VECTOR[7:0];
    end else if (address == 16'hFFFD) begin
      rd_mux = RESET_VECTOR[15:8];
    end
  end

  // RAM array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_hit && !read_write) mem[ram_idx] <= data_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_read <= 8'h00;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      rx_full   <= 1'b0;
      rx_byte   <= 8'h00;
      for (int i = 0; i < TX_DEPTH; i++) fifo[i] <= 8'h00;
    end else begin
      if (read_write) data_read <= rd_mux;
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) begin
        fifo[wr_ptr] <= data_write;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (wr_tx && !push_ok) overflow <= 1'b1;
      else if (rd_status)    overflow <= 1'b0;
      // A CPU drain and a producer offer never coincide: rx_ready was low.
      if (rd_rx && rx_full) begin
        rx_full <= 1'b0;
      end else if (rx_load) begin
        rx_full <= 1'b1;
        rx_byte <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a behavioural model queues the expected
// post-edge view of every bus cycle; a monitor pops and compares after each edge.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_write;
  logic [7:0]  data_read;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  memory_responder dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read_write(read_write),
    .data_write(data_write), .data_read(data_read), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         chk_read;
    logic [7:0] exp_read;
    bit         exp_tx_valid;
    logic [7:0] exp_head;
    bit         exp_rx_ready;
  } entry_t;

  entry_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0] m_ram [2048];
  bit         m_written [2048];
  logic [7:0] m_txq[$];
  bit         m_ovf;
  bit         m_rx_full;
  logic [7:0] m_rx_byte;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txq.delete();
    m_ovf     = 1'b0;
    m_rx_full = 1'b0;
    m_rx_byte = 8'h00;
  endtask

  // One bus cycle: drive at the falling edge, predict the effect of the next rising edge.
  task automatic access(input logic [15:0] a, input bit rw, input logic [7:0] wd,
                        input bit txr, input bit rxv, input logic [7:0] rxd);
    entry_t e;
    bit pop, rx_load;
    int occ;
    @(negedge clk);
    address = a; read_write = rw; data_write = wd;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    e.chk_read = 1'b0;
    e.exp_read = 8'h00;
    occ     = m_txq.size();
    pop     = (occ > 0) && txr;
    rx_load = rxv && !m_rx_full;
    if (a < 16'd2048) begin
      if (rw) begin
        e.chk_read = m_written[a];
        e.exp_read = m_ram[a];
      end else begin
        m_ram[a]     = wd;
        m_written[a] = 1'b1;
      end
    end else if (a[15:8] == 8'hD0) begin
      if (rw) begin
        e.chk_read = 1'b1;
        if (a[7:0] == 8'h01) begin
          e.exp_read = {4'b0, m_ovf, m_rx_full, occ == 0, occ == 4};
          m_ovf = 1'b0;
        end else if (a[7:0] == 8'h02 && m_rx_full) begin
          e.exp_read = m_rx_byte;
          m_rx_full  = 1'b0;
        end
      end
    end else begin
      e.chk_read = rw;
      if (a == 16'hFFFC)      e.exp_read = 8'h00;
      else if (a == 16'hFFFD) e.exp_read = 8'h02;
    end
    if (pop) void'(m_txq.pop_front());
    if (!rw && a[15:8] == 8'hD0 && a[7:0] == 8'h00) begin
      if (m_txq.size() < 4) m_txq.push_back(wd);
      else                  m_ovf = 1'b1;
    end
    if (rx_load) begin
      m_rx_full = 1'b1;
      m_rx_byte = rxd;
    end
    e.exp_tx_valid = m_txq.size() > 0;
    e.exp_head     = e.exp_tx_valid ? m_txq[0] : 8'h00;
    e.exp_rx_ready = !m_rx_full;
    sb.push_back(e);
  endtask

  task automatic idle(input bit txr);
    access(16'h5000, 1'b1, 8'h00, txr, 1'b0, 8'h00);
  endtask

  task automatic drive_idle();
    address = 16'h5000; read_write = 1'b1; data_write = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  // Monitor: one scoreboard entry per rising edge at which an access was driven.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_read) check("data_read", data_read, e.exp_read);
        check("tx_valid", 8'(tx_valid), 8'(e.exp_tx_valid));
        if (e.exp_tx_valid) check("tx_data", tx_data, e.exp_head);
        check("rx_ready", 8'(rx_ready), 8'(e.exp_rx_ready));
      end
    end
  end

  initial begin
    logic [15:0] a;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2048; i++) m_written[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("reset data_read", data_read, 8'h00);
    check("reset tx_valid", 8'(tx_valid), 8'h00);
    check("reset tx_data", tx_data, 8'h00);
    check("reset rx_ready", 8'(rx_ready), 8'h01);
    rst_n = 1'b1;

    // Vectors and unmapped read
    access(16'hFFFC, 1, 8'h00, 0, 0, 8'h00);
    access(16'hFFFD, 1, 8'h00, 0, 0, 8'h00);
    access(16'h5000, 1, 8'h00, 0, 0, 8'h00);
    // RAM write-then-read, unmapped write ignored
    access(16'h0123, 0, 8'hA5, 0, 0, 8'h00);
    access(16'h0123, 1, 8'h00, 0, 0, 8'h00);
    access(16'h0800, 0, 8'h3C, 0, 0, 8'h00);
    access(16'h0800, 1, 8'h00, 0, 0, 8'h00);

    // Overflow on the fifth push, sticky until STATUS read, then drain
    for (int i = 1; i <= 5; i++) access(16'hD000, 0, 8'(i * 8'h11), 0, 0, 8'h00);
    access(16'hD001, 1, 8'h00, 0, 0, 8'h00);
    access(16'hD001, 1, 8'h00, 0, 0, 8'h00);
    repeat (5) idle(1'b1);
    access(16'hD001, 1, 8'h00, 0, 0, 8'h00);

    // Full FIFO with simultaneous pop and push is accepted
    for (int i = 1; i <= 4; i++) access(16'hD000, 0, 8'(i * 8'h11), 0, 0, 8'h00);
    access(16'hD000, 0, 8'h66, 1, 0, 8'h00);
    access(16'hD001, 1, 8'h00, 0, 0, 8'h00);
    repeat (5) idle(1'b1);

    // Receive latch fill, drain, empty read; concurrent offer while full
    access(16'h5000, 1, 8'h00, 0, 1, 8'h7E);
    access(16'hD001, 1, 8'h00, 0, 0, 8'h00);
    access(16'hD002, 1, 8'h00, 0, 1, 8'h99);
    access(16'hD002, 1, 8'h00, 0, 0, 8'h00);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) access(16'hD000, 0, 8'(8'hA0 + i), 0, 0, 8'h00);
    idle(1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("async reset tx_valid", 8'(tx_valid), 8'h00);
    check("async reset rx_ready", 8'(rx_ready), 8'h01);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(16'hD001, 1, 8'h00, 0, 0, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = 16'($urandom_range(0, 31));
        3, 4, 5: a = {8'hD0, 8'($urandom_range(0, 4))};
        6:       a = 16'hFFFC + 16'($urandom_range(0, 3));
        default: a = 16'($urandom_range(16'h0800, 16'hFFFF));
      endcase
      access(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 8'($urandom));
    end
    repeat (6) idle(1'b1);
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
